// File: rtl/mem_port_arbiter.sv
// Shared memory-port sequencer: arbitrates WB write, MEM read and fetch read,
// tracks the fixed read latency and returns registered read data to the owner.
module mem_port_arbiter #(
   parameter int unsigned MEM_LAT    = 3,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_req,
   input  logic [31:0] wb_addr,
   input  logic [31:0] wb_data,
   output logic        wb_gnt,
   input  logic        mr_req,
   input  logic [31:0] mr_addr,
   output logic        mr_gnt,
   output logic        mr_rvld,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvld,
   output logic [47:0] rd_data,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_rd,
   output logic        mem_wr,
   input  logic [47:0] mem_rdata,
   output logic        stall_mem,
   output logic        stall_if,
   output logic        busy
);

   localparam int unsigned CNT_W = 3;
   localparam int unsigned STV_W = 4;

   typedef enum logic {
      IDLE    = 1'b0,
      RD_WAIT = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_MR   = 2'd1,
      OWN_IF   = 2'd2
   } owner_t;

   state_t           state;
   owner_t           owner;
   logic [CNT_W-1:0] cnt;
   logic [STV_W-1:0] starve;
   logic             arb_en;
   logic             fetch_first;

   // Grant, command and stall decode; everything gated off while in reset.
   always_comb begin
      arb_en      = 1'b0;
      fetch_first = 1'b0;
      wb_gnt      = 1'b0;
      mr_gnt      = 1'b0;
      if_gnt      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      mem_rd      = 1'b0;
      mem_wr      = 1'b0;
      busy        = 1'b0;
      stall_mem   = 1'b0;
      stall_if    = 1'b0;

      arb_en      = rst && (state == IDLE);
      fetch_first = (starve == STV_W'(STARVE_MAX));
      wb_gnt      = arb_en && wb_req;
      mr_gnt      = arb_en && !wb_req && mr_req && (!fetch_first || !if_req);
      if_gnt      = arb_en && !wb_req && if_req && (fetch_first || !mr_req);
      mem_wr      = wb_gnt;
      mem_rd      = mr_gnt || if_gnt;
      busy        = (state == RD_WAIT);

      if (wb_gnt) begin
         mem_addr  = wb_addr;
         mem_wdata = wb_data;
      end else if (mr_gnt) begin
         mem_addr  = mr_addr;
      end else if (if_gnt) begin
         mem_addr  = if_addr;
      end

      stall_mem = rst && ((mr_req && !mr_gnt) || ((owner == OWN_MR) && busy));
      stall_if  = rst && ((if_req && !if_gnt) || ((owner == OWN_IF) && busy));
   end

   // Sequencer: read latency countdown, data capture, owner and starvation tracking.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         owner   <= OWN_NONE;
         cnt     <= '0;
         starve  <= '0;
         rd_data <= '0;
         mr_rvld <= 1'b0;
         if_rvld <= 1'b0;
      end else begin
         mr_rvld <= 1'b0;
         if_rvld <= 1'b0;
         case (state)
            IDLE: begin
               if (if_gnt) begin
                  starve <= '0;
               end else if (if_req && (starve != STV_W'(STARVE_MAX))) begin
                  starve <= starve + STV_W'(1);
               end
               if (mr_gnt || if_gnt) begin
                  state <= RD_WAIT;
                  cnt   <= CNT_W'(MEM_LAT - 1);
                  owner <= if_gnt ? OWN_IF : OWN_MR;
               end
            end
            RD_WAIT: begin
               if (cnt == '0) begin
                  rd_data <= mem_rdata;
                  mr_rvld <= (owner == OWN_MR);
                  if_rvld <= (owner == OWN_IF);
                  state   <= IDLE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
         endcase
      end
   end

endmodule
